// File: rtl/adder_result_serializer_if.sv
// Handshake bundle between the adder result capture side and the narrow beat consumer.
interface adder_result_serializer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 4
);
  logic                      i_en;
  logic [DATA_WIDTH:0]       result;
  logic                      i_ovf_clr;
  logic                      i_ready;
  logic                      o_valid;
  logic [WORD_WIDTH-1:0]     o_data;
  logic                      o_last;
  logic [$clog2(DEPTH):0]    o_level;
  logic                      o_ovf;

  modport master (
    output i_en, result, i_ovf_clr, i_ready,
    input  o_valid, o_data, o_last, o_level, o_ovf
  );

  modport slave (
    input  i_en, result, i_ovf_clr, i_ready,
    output o_valid, o_data, o_last, o_level, o_ovf
  );
endinterface

// File: rtl/adder_result_serializer.sv
// Captures adder sums into a small FIFO and streams each one LSB-first as
// WORD_WIDTH beats over valid/ready, flagging sums dropped while full.
module adder_result_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adder_result_serializer_if.slave bus
);
  localparam int SUM_W  = DATA_WIDTH + 1;
  localparam int BEATS  = (SUM_W + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int PAD_W  = BEATS * WORD_WIDTH;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

  logic [SUM_W-1:0]  mem_q [DEPTH];
  logic [SUM_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              ovf_q, ovf_d;

  logic              valid;
  logic              last;
  logic              xfer;
  logic              pop;
  logic              push;
  logic              drop;
  logic [PAD_W-1:0]  head_pad;

  assign valid    = (level_q != '0);
  assign last     = valid && (beat_q == LAST_BEAT);
  assign xfer     = valid && bus.i_ready;
  assign pop      = xfer && (beat_q == LAST_BEAT);
  // A full FIFO still accepts a sum when the head leaves on the same edge.
  assign push     = bus.i_en && ((level_q != FULL_LVL) || pop);
  assign drop     = bus.i_en && !push;
  assign head_pad = PAD_W'(mem_q[rd_ptr_q]);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    beat_d   = beat_q;
    ovf_d    = ovf_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.result;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (xfer) begin
      if (pop) begin
        beat_d   = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.i_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sum storage; contents are meaningless whenever level is zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.o_valid = valid;
  assign bus.o_last  = last;
  assign bus.o_data  = valid ? head_pad[beat_q*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign bus.o_level = level_q;
  assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_adder_result_serializer.sv
// Scoreboard bench for adder_result_serializer: stimulus queues expected beats,
// a negedge monitor checks every accepted beat plus stall and mid-sum behaviour.
module tb_adder_result_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [16:0] exp_q[$];

  adder_result_serializer_if #(.DATA_WIDTH(64), .WORD_WIDTH(16), .DEPTH(4)) bus ();

  adder_result_serializer #(.DATA_WIDTH(64), .WORD_WIDTH(16), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp5(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                      input logic [15:0] b3, input logic [15:0] b4);
    exp_q.push_back({1'b0, b0});
    exp_q.push_back({1'b0, b1});
    exp_q.push_back({1'b0, b2});
    exp_q.push_back({1'b0, b3});
    exp_q.push_back({1'b1, b4});
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.o_valid) && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_done", {63'd0, (exp_q.size() == 0 && !bus.o_valid)}, 64'd1);
  endtask

  // Monitor: compares each accepted beat and watches stall/mid-sum rules
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic        prev_last  = 1'b0;
  logic        in_sum     = 1'b0;

  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        in_sum     = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {63'd0, bus.o_valid}, 64'd1);
          check("stall_data",  {48'd0, bus.o_data}, {48'd0, prev_data});
          check("stall_last",  {63'd0, bus.o_last}, {63'd0, prev_last});
        end
        if (in_sum) check("valid_mid_sum", {63'd0, bus.o_valid}, 64'd1);
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {48'd0, bus.o_data}, 64'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", {48'd0, bus.o_data}, {48'd0, e[15:0]});
            check("beat_last", {63'd0, bus.o_last}, {63'd0, e[16]});
          end
          in_sum = !bus.o_last;
        end
        prev_stall = bus.o_valid && !bus.i_ready;
        prev_data  = bus.o_data;
        prev_last  = bus.o_last;
      end
    end
  end

  initial begin
    logic [11:0] pat;
    bus.i_en      = 1'b0;
    bus.result    = '0;
    bus.i_ovf_clr = 1'b0;
    bus.i_ready   = 1'b0;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {63'd0, bus.o_valid}, 64'd0);
    check("rst_data",  {48'd0, bus.o_data}, 64'd0);
    check("rst_last",  {63'd0, bus.o_last}, 64'd0);
    check("rst_level", {61'd0, bus.o_level}, 64'd0);
    check("rst_ovf",   {63'd0, bus.o_ovf}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single sum
    bus.i_ready = 1'b1;
    bus.i_en    = 1'b1;
    bus.result  = 65'h1_0123_4567_89AB_CDEF;
    exp5(16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, 16'h0001);
    tick();
    bus.i_en = 1'b0;
    check("single_level1", {61'd0, bus.o_level}, 64'd1);
    check("single_valid",  {63'd0, bus.o_valid}, 64'd1);
    check("single_beat0",  {48'd0, bus.o_data}, 64'hCDEF);
    tick(); tick(); tick(); tick();
    check("single_level_hold", {61'd0, bus.o_level}, 64'd1);
    tick();
    check("single_level0", {61'd0, bus.o_level}, 64'd0);
    wait_drain(20);

    // Backpressure
    bus.i_ready = 1'b0;
    bus.i_en    = 1'b1;
    bus.result  = 65'h1_0123_4567_89AB_CDEF;
    exp5(16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, 16'h0001);
    tick();
    bus.i_en = 1'b0;
    pat = 12'b1110_0110_1001;
    for (int i = 0; i < 12; i++) begin
      bus.i_ready = pat[i];
      tick();
    end
    bus.i_ready = 1'b1;
    wait_drain(20);

    // Fill and overflow, with a clear colliding with the drop
    bus.i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus.i_en   = 1'b1;
      bus.result = 65'(k);
      exp5(16'(k), 16'h0, 16'h0, 16'h0, 16'h0);
      tick();
    end
    check("fill_level4", {61'd0, bus.o_level}, 64'd4);
    check("fill_ovf0",   {63'd0, bus.o_ovf}, 64'd0);
    bus.result    = 65'd5;
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_en      = 1'b0;
    bus.i_ovf_clr = 1'b0;
    check("drop_ovf",   {63'd0, bus.o_ovf}, 64'd1);
    check("drop_level", {61'd0, bus.o_level}, 64'd4);
    bus.i_ready = 1'b1;
    wait_drain(40);
    check("ovf_sticky", {63'd0, bus.o_ovf}, 64'd1);
    bus.i_ovf_clr = 1'b1;
    tick();
    bus.i_ovf_clr = 1'b0;
    check("ovf_cleared", {63'd0, bus.o_ovf}, 64'd0);

    // Push on last-beat pop while full
    bus.i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.i_en   = 1'b1;
      bus.result = 65'(8'h11 + k);
      exp5(16'(8'h11 + k), 16'h0, 16'h0, 16'h0, 16'h0);
      tick();
    end
    bus.i_en    = 1'b0;
    bus.i_ready = 1'b1;
    tick(); tick(); tick(); tick();
    bus.i_en   = 1'b1;
    bus.result = 65'h15;
    exp5(16'h0015, 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    bus.i_en = 1'b0;
    check("pushpop_level", {61'd0, bus.o_level}, 64'd4);
    check("pushpop_ovf",   {63'd0, bus.o_ovf}, 64'd0);
    wait_drain(40);

    // Pointer wrap: 10 sums at 5-cycle spacing
    for (int k = 0; k < 10; k++) begin
      bus.i_en   = 1'b1;
      bus.result = 65'(k);
      exp5(16'(k), 16'h0, 16'h0, 16'h0, 16'h0);
      tick();
      bus.i_en = 1'b0;
      tick(); tick(); tick(); tick();
    end
    wait_drain(20);
    check("wrap_ovf", {63'd0, bus.o_ovf}, 64'd0);

    // Reset mid-sum with two entries queued behind the head
    bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_en   = 1'b1;
      bus.result = 65'(8'h21 + k);
      exp5(16'(8'h21 + k), 16'h0, 16'h0, 16'h0, 16'h0);
      tick();
    end
    bus.i_en    = 1'b0;
    bus.i_ready = 1'b1;
    tick(); tick(); tick();
    check("pre_rst_level", {61'd0, bus.o_level}, 64'd3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", {63'd0, bus.o_valid}, 64'd0);
    check("mid_rst_data",  {48'd0, bus.o_data}, 64'd0);
    check("mid_rst_last",  {63'd0, bus.o_last}, 64'd0);
    check("mid_rst_level", {61'd0, bus.o_level}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", {63'd0, bus.o_valid}, 64'd0);
    end
    bus.i_en   = 1'b1;
    bus.result = 65'h1_0000_0000_0000_0030;
    exp5(16'h0030, 16'h0, 16'h0, 16'h0, 16'h0001);
    tick();
    bus.i_en = 1'b0;
    check("post_rst_beat0", {48'd0, bus.o_data}, 64'h0030);
    wait_drain(20);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
